// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - multi-channel vending dispense sequencer with debounced drop sensing
// Drives one relay per selection, confirms the drop, times out stuck motors and locks out faulty channels.
module vend_dispense_ctrl #(
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5,
    parameter int TIMEOUT    = 3000,
    parameter int TO_W       = 12
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            sel_valid_in,
    input  logic [CH_W-1:0] sel_ch_in,
    output logic            sel_ready_out,
    input  logic [N_CH-1:0] sensor1_in,
    input  logic [N_CH-1:0] sensor2_in,
    input  logic            clr_fault_in,
    output logic [N_CH-1:0] rele_out,
    output logic            busy_out,
    output logic            done_out,
    output logic [1:0]      status_out,
    output logic [N_CH-1:0] fault_mask_out
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRIVE, S_DONE} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_INVALID = 2'b10;
    localparam logic [1:0] ST_BLOCKED = 2'b11;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [1:0]        code_q, code_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   det_q;
    logic [N_CH-1:0]   raw;
    logic [N_CH-1:0]   ch_oh;
    logic [DEB_W-1:0]  deb_cnt_q [N_CH];

    // Both sensors of a pair must see the object to count as a drop.
    assign raw = ~sensor1_in & ~sensor2_in;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            det_q <= '0;
            for (int i = 0; i < N_CH; i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (raw[i] == det_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    det_q[i]     <= ~det_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // An out-of-range channel shifts the one off the top, leaving an all-zero one-hot.
    assign ch_oh = N_CH'(1) << ch_q;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            code_q  <= ST_OK;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        mask_d  = clr_fault_in ? '0 : mask_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid_in) begin
                    ch_d    = sel_ch_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (ch_oh == '0 || (mask_q & ch_oh) != '0) begin
                    code_d  = ST_INVALID;
                    state_d = S_DONE;
                end else if ((det_q & ch_oh) != '0) begin
                    code_d  = ST_BLOCKED;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // A drop seen on the last allowed cycle still counts as delivered.
                if ((det_q & ch_oh) != '0) begin
                    code_d  = ST_OK;
                    state_d = S_DONE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    code_d  = ST_TIMEOUT;
                    mask_d  = mask_d | ch_oh;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel_ready_out  = (state_q == S_IDLE);
    assign busy_out       = (state_q != S_IDLE);
    assign done_out       = (state_q == S_DONE);
    assign status_out     = code_q;
    assign rele_out       = (state_q == S_DRIVE) ? ch_oh : '0;
    assign fault_mask_out = mask_q;

endmodule
